// File: rtl/ex_pipe_ctrl_pkg.sv
// ============================================================================
//  ex_pipe_ctrl_pkg : shared encodings and constants for the EX pipeline ctrl
//  Rev 1.0
// ============================================================================
`default_nettype none

package ex_pipe_ctrl_pkg;

   typedef enum logic [0:0] {
      EXC_RUN   = 1'b0,
      EXC_FLUSH = 1'b1
   } exc_state_e;

   localparam logic [4:0]  REG_X0     = 5'd0;
   localparam logic [31:0] INST_BYTES = 32'd4;
   localparam logic        ENABLE     = 1'b1;
   localparam logic        DISABLE    = 1'b0;

endpackage

`default_nettype wire

// File: rtl/ex_pipe_ctrl_if.sv
// ============================================================================
//  ex_pipe_ctrl_if : decode/execute-facing signal bundle of the EX controller
//  Rev 1.0
// ============================================================================
`default_nettype none

interface ex_pipe_ctrl_if #(
   parameter int CNT_W = 32
) ();
   logic             id_valid;
   logic [31:0]      id_pc;
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             id_use_rs1;
   logic             id_use_rs2;
   logic             id_is_load;
   logic [4:0]       id_rd;
   logic [31:0]      ex_npc;
   logic             ex_valid;
   logic [31:0]      ex_pc;
   logic             ex_commit;
   logic             stall;
   logic             flush;
   logic             redirect_valid;
   logic [31:0]      redirect_pc;
   logic [CNT_W-1:0] commit_cnt;
   logic [CNT_W-1:0] redirect_cnt;

   modport master (
      output id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             id_is_load, id_rd, ex_npc,
      input  ex_valid, ex_pc, ex_commit, stall, flush, redirect_valid,
             redirect_pc, commit_cnt, redirect_cnt
   );

   modport slave (
      input  id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             id_is_load, id_rd, ex_npc,
      output ex_valid, ex_pc, ex_commit, stall, flush, redirect_valid,
             redirect_pc, commit_cnt, redirect_cnt
   );
endinterface

`default_nettype wire

// File: rtl/ex_pipe_ctrl_load_use_detect.sv
// ============================================================================
//  ex_pipe_ctrl_load_use_detect : combinational load-use hazard detector
//  Rev 1.0
// ============================================================================
`default_nettype none

module ex_pipe_ctrl_load_use_detect
   import ex_pipe_ctrl_pkg::*;
(
   input  wire logic       i_state_run,
   input  wire logic       i_ex_valid,
   input  wire logic       i_ex_is_load,
   input  wire logic [4:0] i_ex_rd,
   input  wire logic       i_id_valid,
   input  wire logic       i_id_use_rs1,
   input  wire logic [4:0] i_id_rs1,
   input  wire logic       i_id_use_rs2,
   input  wire logic [4:0] i_id_rs2,
   output logic            o_hazard
);
   logic w_src_match;

   assign w_src_match = (i_id_use_rs1 && (i_id_rs1 == i_ex_rd)) ||
                        (i_id_use_rs2 && (i_id_rs2 == i_ex_rd));

   // x0 never carries a real dependency, so a load into it cannot cause a bubble
   assign o_hazard = i_state_run && i_ex_valid && i_ex_is_load &&
                     (i_ex_rd != REG_X0) && i_id_valid && w_src_match;
endmodule

`default_nettype wire

// File: rtl/ex_pipe_ctrl.sv
// ============================================================================
//  ex_pipe_ctrl : EX-stage pipeline controller (ID->EX register, redirect,
//                 load-use stall, flush drain, saturating perf counters)
//  Rev 1.0
// ============================================================================
`default_nettype none

module ex_pipe_ctrl #(
   parameter int FLUSH_DEPTH = 2,
   parameter int CNT_W       = 32
) (
   input  wire logic       clk,
   input  wire logic       rst,
   ex_pipe_ctrl_if.slave   bus
);
   import ex_pipe_ctrl_pkg::*;

   localparam int FC_W = (FLUSH_DEPTH > 2) ? $clog2(FLUSH_DEPTH) : 1;

   exc_state_e       r_state;
   logic [FC_W-1:0]  r_flush_cnt;
   logic             r_ex_valid;
   logic [31:0]      r_ex_pc;
   logic             r_ex_is_load;
   logic [4:0]       r_ex_rd;
   logic [CNT_W-1:0] r_commit_cnt;
   logic [CNT_W-1:0] r_redirect_cnt;

   logic [31:0]      w_seq_pc;
   logic             w_redirect;
   logic             w_hazard;
   logic             w_flush;
   logic             w_stall;

   assign w_seq_pc   = r_ex_pc + INST_BYTES;
   assign w_redirect = r_ex_valid && (bus.ex_npc != w_seq_pc);
   assign w_flush    = w_redirect || (r_state == EXC_FLUSH);
   // Redirect wins: anything younger than the redirecting instruction is wrong-path
   assign w_stall    = w_hazard && !w_redirect;

   ex_pipe_ctrl_load_use_detect u_load_use_detect (
      .i_state_run  (r_state == EXC_RUN),
      .i_ex_valid   (r_ex_valid),
      .i_ex_is_load (r_ex_is_load),
      .i_ex_rd      (r_ex_rd),
      .i_id_valid   (bus.id_valid),
      .i_id_use_rs1 (bus.id_use_rs1),
      .i_id_rs1     (bus.id_rs1),
      .i_id_use_rs2 (bus.id_use_rs2),
      .i_id_rs2     (bus.id_rs2),
      .o_hazard     (w_hazard)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= EXC_RUN;
         r_flush_cnt    <= '0;
         r_ex_valid     <= DISABLE;
         r_ex_pc        <= '0;
         r_ex_is_load   <= DISABLE;
         r_ex_rd        <= REG_X0;
         r_commit_cnt   <= '0;
         r_redirect_cnt <= '0;
      end else begin
         if (w_flush || w_hazard) begin
            r_ex_valid <= DISABLE;
         end else begin
            r_ex_valid   <= bus.id_valid;
            r_ex_pc      <= bus.id_pc;
            r_ex_rd      <= bus.id_rd;
            r_ex_is_load <= bus.id_is_load;
         end

         // The redirect cycle itself is the first flush cycle, hence the -2 preload
         case (r_state)
            EXC_RUN: begin
               if (w_redirect && (FLUSH_DEPTH > 1)) begin
                  r_state     <= EXC_FLUSH;
                  r_flush_cnt <= FC_W'(FLUSH_DEPTH - 2);
               end
            end
            EXC_FLUSH: begin
               if (r_flush_cnt == '0) begin
                  r_state <= EXC_RUN;
               end else begin
                  r_flush_cnt <= r_flush_cnt - 1'b1;
               end
            end
         endcase

         if (r_ex_valid && (r_commit_cnt != '1)) begin
            r_commit_cnt <= r_commit_cnt + 1'b1;
         end
         if (w_redirect && (r_redirect_cnt != '1)) begin
            r_redirect_cnt <= r_redirect_cnt + 1'b1;
         end
      end
   end

   assign bus.ex_valid       = r_ex_valid;
   assign bus.ex_pc          = r_ex_pc;
   assign bus.ex_commit      = r_ex_valid;
   assign bus.stall          = w_stall;
   assign bus.flush          = w_flush;
   assign bus.redirect_valid = w_redirect;
   assign bus.redirect_pc    = bus.ex_npc;
   assign bus.commit_cnt     = r_commit_cnt;
   assign bus.redirect_cnt   = r_redirect_cnt;
endmodule

`default_nettype wire
